// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT bit-reversal reorder buffer.
// Module-level parameters override the defaults declared here.
package fft_pkg;

  localparam int FP_DEF   = 64;
  localparam int LOGN_DEF = 8;
  localparam int MAX_LOGN = 16;

  typedef struct packed {
    logic [FP_DEF-1:0] re;
    logic [FP_DEF-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // N = 2^logn samples per frame
  function automatic int frame_len(input int lg);
    return 1 << lg;
  endfunction

  // Reverse the low 'bits' bits of v; upper bits of the result are zero
  function automatic logic [MAX_LOGN-1:0] bitrev(input logic [MAX_LOGN-1:0] v, input int bits);
    logic [MAX_LOGN-1:0] rev;
    rev = {<<{v}};
    return rev >> (MAX_LOGN - bits);
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module fft_bitrev_reorder_ram
  import fft_pkg::*;
#(
  parameter int WIDTH = 2 * FP_DEF,
  parameter int AW    = LOGN_DEF + 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT output into one bank while
// the previous frame is streamed out of the other bank in natural order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int FLOAT_PRECISION = FP_DEF,
  parameter int logn            = LOGN_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [FLOAT_PRECISION-1:0] di_re,
  input  logic [FLOAT_PRECISION-1:0] di_im,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic [logn-1:0]            out_idx,
  output logic [FLOAT_PRECISION-1:0] do_re,
  output logic [FLOAT_PRECISION-1:0] do_im,
  output logic                       busy
);

  localparam int N = frame_len(logn);
  localparam int W = 2 * FLOAT_PRECISION;
  localparam logic [logn-1:0] LAST = logn'(N - 1);

  logic [logn-1:0] r_wr_cnt, r_rd_cnt, r_out_idx;
  logic            r_wr_bank, r_pending, r_pending_bank, r_rd_bank;
  logic            r_out_valid, r_out_first, r_out_last, r_data_ok;
  rd_state_t       r_state, w_state_nxt;
  logic            w_wr_en, w_wr_last, w_pend_now, w_pend_bank, w_take, w_rd_en;
  logic [logn-1:0] w_wr_idx;
  logic [W-1:0]    w_rd_data;

  assign w_wr_en     = in_valid & ~clr;
  assign w_wr_last   = w_wr_en & (r_wr_cnt == LAST);
  // A frame completing on this very edge may be picked up without a bubble
  assign w_pend_now  = r_pending | w_wr_last;
  assign w_pend_bank = r_pending ? r_pending_bank : r_wr_bank;
  assign w_wr_idx    = logn'(bitrev(MAX_LOGN'(r_wr_cnt), logn));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt       <= '0;
      r_wr_bank      <= 1'b0;
      r_pending      <= 1'b0;
      r_pending_bank <= 1'b0;
    end else if (clr) begin
      r_wr_cnt  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_last) begin
        r_wr_bank      <= ~r_wr_bank;
        r_pending_bank <= r_wr_bank;
      end
      r_pending <= w_pend_now & ~w_take;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_take      = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_rd_en = 1'b1;
        if (r_rd_cnt == LAST) begin
          if (w_pend_now) w_take = 1'b1;
          else            w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clr) begin
      w_state_nxt = IDLE;
      w_take      = 1'b0;
      w_rd_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clr) begin
        r_rd_cnt <= '0;
      end else if (w_take) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= w_pend_bank;
      end else if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  // Output flags align with the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
      r_data_ok   <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
      r_out_first <= w_rd_en & (r_rd_cnt == '0);
      r_out_last  <= w_rd_en & (r_rd_cnt == LAST);
      if (w_rd_en) begin
        r_out_idx <= r_rd_cnt;
        r_data_ok <= 1'b1;
      end
    end
  end

  fft_bitrev_reorder_ram #(
    .WIDTH (W),
    .AW    (logn + 1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr ({r_wr_bank, w_wr_idx}),
    .i_wdata ({di_re, di_im}),
    .i_re    (w_rd_en),
    .i_raddr ({r_rd_bank, r_rd_cnt}),
    .o_rdata (w_rd_data)
  );

  // The RAM read register has no reset, so data reads as zero until the first read
  assign do_re     = r_data_ok ? w_rd_data[W-1:FLOAT_PRECISION] : '0;
  assign do_im     = r_data_ok ? w_rd_data[FLOAT_PRECISION-1:0] : '0;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state == READ);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: a logn=3 instance for directed timing cases and a
// logn=8 instance for randomized gapped traffic, both checked against a frame model.
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr3, clr8, v3, v8;
  logic [63:0] re3, im3, re8, im8;
  logic        ov3, of3, ol3, busy3, ov8, of8, ol8, busy8;
  logic [2:0]  oi3;
  logic [7:0]  oi8;
  logic [63:0] do_re3, do_im3, do_re8, do_im8;

  fft_bitrev_reorder #(.FLOAT_PRECISION(64), .logn(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr3), .in_valid(v3), .di_re(re3), .di_im(im3),
    .out_valid(ov3), .out_first(of3), .out_last(ol3), .out_idx(oi3),
    .do_re(do_re3), .do_im(do_im3), .busy(busy3));

  fft_bitrev_reorder #(.FLOAT_PRECISION(64), .logn(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .in_valid(v8), .di_re(re8), .di_im(im8),
    .out_valid(ov8), .out_first(of8), .out_last(ol8), .out_idx(oi8),
    .do_re(do_re8), .do_im(do_im8), .busy(busy8));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_bitrev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each completed frame yields natural index j = sample at position bitrev(j)
  cplx_t        m3 [8];
  cplx_t        m8 [256];
  int           c3 = 0;
  int           c8 = 0;
  logic [137:0] exp3_q[$];
  logic [137:0] exp8_q[$];

  task automatic send3(input logic [63:0] r, input logic [63:0] i);
    v3 = 1'b1; re3 = r; im3 = i;
    m3[3'(c3)] = '{re: r, im: i};
    c3++;
    if (c3 == 8) begin
      for (int j = 0; j < 8; j++)
        exp3_q.push_back({j == 0, j == 7, 8'(j), m3[3'(ref_bitrev(j, 3))]});
      c3 = 0;
    end
    tick();
    v3 = 1'b0;
  endtask

  task automatic send8(input logic [63:0] r, input logic [63:0] i);
    v8 = 1'b1; re8 = r; im8 = i;
    m8[8'(c8)] = '{re: r, im: i};
    c8++;
    if (c8 == 256) begin
      for (int j = 0; j < 256; j++)
        exp8_q.push_back({j == 0, j == 255, 8'(j), m8[8'(ref_bitrev(j, 8))]});
      c8 = 0;
    end
    tick();
    v8 = 1'b0;
  endtask

  task automatic send3_rand_frame();
    for (int k = 0; k < 8; k++) send3({$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Output monitors: compare every valid beat and measure run lengths
  int           run3 = 0;
  int           last_run3 = 0;
  int           run8 = 0;
  int           brun8 = 0;
  logic [137:0] e3, e8;

  always @(negedge clk) begin
    if (ov3) begin
      run3++;
      if (exp3_q.size() == 0) chk("u3_unexpected_valid", 192'(ov3), 192'(1'b0));
      else begin
        e3 = exp3_q.pop_front();
        chk("u3_out", 192'({of3, ol3, 5'b0, oi3, do_re3, do_im3}), 192'(e3));
      end
    end else if (run3 != 0) begin
      last_run3 = run3;
      run3 = 0;
    end
  end

  always @(negedge clk) begin
    if (ov8) begin
      run8++;
      if (exp8_q.size() == 0) chk("u8_unexpected_valid", 192'(ov8), 192'(1'b0));
      else begin
        e8 = exp8_q.pop_front();
        chk("u8_out", 192'({of8, ol8, oi8, do_re8, do_im8}), 192'(e8));
      end
    end else if (run8 != 0) begin
      chk("u8_valid_run", 192'(run8), 192'(256));
      run8 = 0;
    end
    if (busy8) brun8++;
    else if (brun8 != 0) begin
      chk("u8_busy_run", 192'(brun8), 192'(256));
      brun8 = 0;
    end
  end

  task automatic drain3();
    int t = 0;
    while ((exp3_q.size() != 0 || ov3) && t < 200) begin tick(); t++; end
    chk("u3_drain_timeout", 192'(t < 200), 192'(1'b1));
    tick();
  endtask

  task automatic wait_idx3(input logic [2:0] idx);
    int t = 0;
    while (!(ov3 === 1'b1 && oi3 === idx) && t < 100) begin tick(); t++; end
    chk("u3_wait_idx_timeout", 192'(t < 100), 192'(1'b1));
  endtask

  initial begin
    rst_n = 1'b0; clr3 = 1'b0; clr8 = 1'b0; v3 = 1'b0; v8 = 1'b0;
    re3 = '0; im3 = '0; re8 = '0; im8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u3", 192'({ov3, of3, ol3, oi3, do_re3, do_im3, busy3}), 192'(0));
    chk("rst_u8", 192'({ov8, of8, ol8, oi8, do_re8, do_im8, busy8}), 192'(0));
    rst_n = 1'b1;
    tick();

    // Single frame carrying its own natural index; check first-output latency
    for (int k = 0; k < 8; k++) send3(64'(ref_bitrev(k, 3)), 64'(100 + ref_bitrev(k, 3)));
    chk("t1_lat_edge0", 192'(ov3), 192'(1'b0));
    tick();
    chk("t1_lat_edge1", 192'(ov3), 192'(1'b0));
    tick();
    chk("t1_lat_edge2", 192'({ov3, of3, oi3, do_re3}), 192'({1'b1, 1'b1, 3'd0, 64'd0}));
    chk("t1_busy", 192'(busy3), 192'(1'b1));
    drain3();
    chk("t1_run", 192'(last_run3), 192'(8));

    // Three frames back-to-back: one unbroken 24-beat burst
    for (int f = 0; f < 3; f++) send3_rand_frame();
    drain3();
    chk("t2_run", 192'(last_run3), 192'(24));

    // Frame 2 completes on the edge frame 1 emits idx 6
    send3_rand_frame();
    for (int k = 0; k < 7; k++) send3({$urandom, $urandom}, {$urandom, $urandom});
    send3({$urandom, $urandom}, {$urandom, $urandom});
    chk("t6_align", 192'({ov3, oi3}), 192'({1'b1, 3'd6}));
    drain3();
    chk("t6_run", 192'(last_run3), 192'(16));

    // clr after a partial frame, then a full frame
    for (int k = 0; k < 5; k++) send3({$urandom, $urandom}, {$urandom, $urandom});
    clr3 = 1'b1; c3 = 0;
    tick();
    clr3 = 1'b0;
    send3_rand_frame();
    drain3();
    chk("t4_run", 192'(last_run3), 192'(8));

    // clr during a read drops the rest of that frame
    send3_rand_frame();
    wait_idx3(3'd2);
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    exp3_q.delete();
    chk("t4b_clr_stop", 192'({ov3, busy3}), 192'(0));
    send3_rand_frame();
    drain3();
    chk("t4b_run", 192'(last_run3), 192'(8));

    // Asynchronous reset mid-read
    send3_rand_frame();
    wait_idx3(3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst", 192'({ov3, of3, ol3, oi3, do_re3, do_im3, busy3}), 192'(0));
    exp3_q.delete();
    c3 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send3_rand_frame();
    drain3();
    chk("t5_run", 192'(last_run3), 192'(8));

    // logn=8: random data, ~50% input gaps
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 256; k++) begin
        while ($urandom_range(0, 1) == 1) tick();
        send8({$urandom, $urandom}, {$urandom, $urandom});
      end
    end
    begin
      int t = 0;
      while ((exp8_q.size() != 0 || ov8 || busy8) && t < 2000) begin tick(); t++; end
      chk("u8_drain_timeout", 192'(t < 2000), 192'(1'b1));
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
